mbus_rx_framer: RTL and testbench
=================================

// Module: mbus_rx_framer
// PURPOSE
//  Downstream consumer of the bus control stage. Takes the recovered serial bit stream
//  (one strobe per bus clock) and frames it into an address field plus data bytes.
//  Filters on node address and buffers matched bytes in a small FIFO for the local layer.
//  Single clock domain (CLK_IN); bits arrive as 1-cycle strobes, not as a separate clock.
// PARAMETERS
//  ADDR_WIDTH   8      address field length in bits (MSB first)
//  DATA_WIDTH   8      data byte length in bits (MSB first)
//  MY_ADDR      8'hA5  this node's address
//  BCAST_ADDR   8'hFF  broadcast address; always matches
//  FIFO_DEPTH   4      output byte buffer entries (power of 2, >=2)
// PORTS
//  CLK_IN       in   1           system clock; all logic on posedge
//  RESET        in   1           synchronous, active-low reset
//  BIT_IN       in   1           received data bit, valid only with BIT_VALID
//  BIT_VALID    in   1           1-cycle strobe: BIT_IN holds a new bit
//  BUS_IDLE     in   1           level from control stage: bus idle / transaction ended
//  BYTE_READY   in   1           consumer accepts BYTE_OUT this cycle
//  BYTE_OUT     out  DATA_WIDTH  head-of-FIFO data byte
//  BYTE_VALID   out  1           FIFO non-empty; BYTE_OUT valid
//  ADDR_MATCH   out  1           current/last frame address matched MY_ADDR or BCAST_ADDR
//  FRAME_ACTIVE out  1           framer is inside a frame (ADDR, DATA or SKIP)
//  FRAME_END    out  1           1-cycle pulse when a frame terminates
//  FRAME_ERR    out  1           1-cycle pulse with FRAME_END if a partial byte/addr was discarded
//  OVERFLOW     out  1           sticky: a matched byte was dropped because FIFO full
// BEHAVIOUR
//  Reset (RESET==0 at posedge): state IDLE, shift reg/bit counter 0, FIFO empty,
//   all outputs 0 (BYTE_OUT 0). Reset mid-frame discards everything, incl. FIFO contents.
//  States: IDLE, ADDR, DATA, SKIP. All outputs registered.
//  IDLE: BIT_VALID & !BUS_IDLE -> ADDR; that bit is address MSB (counter=1).
//   Also clears OVERFLOW and ADDR_MATCH. BIT_VALID while BUS_IDLE: ignored.
//  ADDR: shift bits MSB first; on ADDR_WIDTH-th bit compare full address:
//   match -> DATA, ADDR_MATCH=1 next cycle; no match -> SKIP, ADDR_MATCH stays 0.
//  DATA: shift bits; on DATA_WIDTH-th bit push byte to FIFO, counter restarts at 0.
//   FIFO full and no pop that cycle -> byte dropped, OVERFLOW=1 (held until next frame start).
//   Full with simultaneous pop -> push accepted.
//  SKIP: all bits ignored until BUS_IDLE.
//  BUS_IDLE high in ADDR/DATA/SKIP -> IDLE next cycle, FRAME_END pulse that cycle;
//   FRAME_ERR pulses too if bit counter !=0 (partial addr/byte discarded, never pushed).
//   BIT_VALID coincident with BUS_IDLE: BUS_IDLE wins, bit discarded.
//  FRAME_ACTIVE = 1 exactly while state is ADDR/DATA/SKIP. ADDR_MATCH held until next frame start.
//  FIFO: BYTE_VALID = !empty; pop on BYTE_VALID & BYTE_READY; BYTE_READY while empty ignored.
//   Latency: last data bit strobe at cycle N -> BYTE_VALID=1, BYTE_OUT=byte at N+1 (FIFO was empty).
//   Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
//  FIFO contents survive FRAME_END; consumer drains across frames.
// TESTING
//  1 Reset: RESET=0 2 cycles with random BIT_VALID -> all outputs 0, BYTE_VALID=0.
//  2 Match: addr 8'hA5 then data 8'h3C,8'hC3, BUS_IDLE, BYTE_READY=1 -> bytes 3C,C3 in order,
//    ADDR_MATCH=1, FRAME_END pulse, FRAME_ERR=0.
//  3 Miss: addr 8'h12 + 2 bytes -> SKIP, no BYTE_VALID, ADDR_MATCH=0, FRAME_END pulse.
//  4 Overflow: addr 8'hFF, 6 bytes 01..06, BYTE_READY=0 -> FIFO holds 01..04, OVERFLOW=1;
//    drain -> 01,02,03,04; next frame start clears OVERFLOW.
//  5 Partial: addr 8'hA5 + 5 data bits then BUS_IDLE -> FRAME_END & FRAME_ERR pulse, no push;
//    BIT_VALID same cycle as BUS_IDLE discarded.
//  6 Mid-frame reset after 3 bytes pushed -> FIFO empty, state IDLE, next frame decodes cleanly.

Source files
------------

// File: rtl/mbus_rx_framer.sv
// Serial receive framer: shifts strobed bits into an address field and data bytes,
// filters frames on node/broadcast address and queues matched bytes in a small FIFO.
module mbus_rx_framer #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] MY_ADDR    = 8'hA5,
  parameter logic [ADDR_WIDTH-1:0] BCAST_ADDR = 8'hFF,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic                  BIT_IN,
  input  logic                  BIT_VALID,
  input  logic                  BUS_IDLE,
  input  logic                  BYTE_READY,
  output logic [DATA_WIDTH-1:0] BYTE_OUT,
  output logic                  BYTE_VALID,
  output logic                  ADDR_MATCH,
  output logic                  FRAME_ACTIVE,
  output logic                  FRAME_END,
  output logic                  FRAME_ERR,
  output logic                  OVERFLOW
);

  localparam int SHIFT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(SHIFT_W + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SKIP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // The newest bit is appended combinationally, so only SHIFT_W-1 bits need storing.
  logic [SHIFT_W-2:0] r_shift;
  logic [SHIFT_W-2:0] w_shift_nxt;
  logic [SHIFT_W-1:0] w_shift_in;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic w_addr_hit;
  logic w_start;
  logic w_match_set;
  logic w_push_req;
  logic w_frame_end;
  logic w_frame_err;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_byte;

  logic r_addr_match;
  logic r_frame_active;
  logic r_frame_end;
  logic r_frame_err;
  logic r_overflow;

  assign w_shift_in = {r_shift, BIT_IN};
  assign w_byte     = w_shift_in[DATA_WIDTH-1:0];
  assign w_addr_hit = (w_shift_in[ADDR_WIDTH-1:0] == MY_ADDR) ||
                      (w_shift_in[ADDR_WIDTH-1:0] == BCAST_ADDR);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_IN) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_match_set = 1'b0;
    w_push_req  = 1'b0;
    w_frame_end = 1'b0;
    w_frame_err = 1'b0;

    if (r_state == S_IDLE) begin
      if (BIT_VALID && !BUS_IDLE) begin
        w_state_nxt = S_ADDR;
        w_shift_nxt = (SHIFT_W - 1)'(BIT_IN);
        w_cnt_nxt   = CNT_W'(1);
        w_start     = 1'b1;
      end
    end else if (BUS_IDLE) begin
      // Bus idle terminates the frame; a bit strobed in the same cycle is dropped.
      w_state_nxt = S_IDLE;
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
      w_frame_end = 1'b1;
      w_frame_err = (r_cnt != '0);
    end else if (BIT_VALID && r_state != S_SKIP) begin
      w_shift_nxt = w_shift_in[SHIFT_W-2:0];
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      case (r_state)
        S_ADDR: begin
          if (r_cnt == ADDR_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = w_addr_hit ? S_DATA : S_SKIP;
            w_match_set = w_addr_hit;
          end
        end
        S_DATA: begin
          if (r_cnt == DATA_LAST) begin
            w_cnt_nxt  = '0;
            w_push_req = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OCC_FULL);
  assign w_pop   = !w_empty && BYTE_READY;
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge CLK_IN) begin
    if (!RESET) begin
      r_shift        <= '0;
      r_cnt          <= '0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_occ          <= '0;
      r_addr_match   <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_end    <= 1'b0;
      r_frame_err    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_shift        <= w_shift_nxt;
      r_cnt          <= w_cnt_nxt;
      r_frame_active <= (w_state_nxt != S_IDLE);
      r_frame_end    <= w_frame_end;
      r_frame_err    <= w_frame_err;

      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase

      if (w_start)          r_addr_match <= 1'b0;
      else if (w_match_set) r_addr_match <= 1'b1;

      if (w_start)     r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is not reset; BYTE_OUT is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge CLK_IN) begin
    if (w_push) r_mem[r_wptr] <= w_byte;
  end

  assign BYTE_OUT     = w_empty ? '0 : r_mem[r_rptr];
  assign BYTE_VALID   = !w_empty;
  assign ADDR_MATCH   = r_addr_match;
  assign FRAME_ACTIVE = r_frame_active;
  assign FRAME_END    = r_frame_end;
  assign FRAME_ERR    = r_frame_err;
  assign OVERFLOW     = r_overflow;

endmodule

// File: tb/tb_mbus_rx_framer.sv
// Directed bench for mbus_rx_framer: expected bytes are queued as they are sent and
// compared when the DUT presents them to an accepting consumer.
module tb_mbus_rx_framer;

  localparam int DEPTH = 4;

  logic       CLK_IN = 1'b0;
  logic       RESET = 1'b0;
  logic       BIT_IN = 1'b0;
  logic       BIT_VALID = 1'b0;
  logic       BUS_IDLE = 1'b1;
  logic       BYTE_READY = 1'b0;
  logic [7:0] BYTE_OUT;
  logic       BYTE_VALID;
  logic       ADDR_MATCH;
  logic       FRAME_ACTIVE;
  logic       FRAME_END;
  logic       FRAME_ERR;
  logic       OVERFLOW;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;

  mbus_rx_framer dut (
    .CLK_IN      (CLK_IN),
    .RESET       (RESET),
    .BIT_IN      (BIT_IN),
    .BIT_VALID   (BIT_VALID),
    .BUS_IDLE    (BUS_IDLE),
    .BYTE_READY  (BYTE_READY),
    .BYTE_OUT    (BYTE_OUT),
    .BYTE_VALID  (BYTE_VALID),
    .ADDR_MATCH  (ADDR_MATCH),
    .FRAME_ACTIVE(FRAME_ACTIVE),
    .FRAME_END   (FRAME_END),
    .FRAME_ERR   (FRAME_ERR),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Consumer side: every accepted byte must be the oldest outstanding expected byte.
  always @(negedge CLK_IN) begin
    if (RESET && BYTE_VALID === 1'b1 && BYTE_READY) begin
      if (exp_q.size() == 0) check("unexpected_byte_valid", 32'(BYTE_VALID), 32'd0);
      else                   check("byte_out", 32'(BYTE_OUT), 32'(exp_q.pop_front()));
    end
  end

  // Back-to-back strobes, MSB first; returns on the negedge just after the last bit's posedge.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      BIT_IN    = v[i];
      BIT_VALID = 1'b1;
      @(negedge CLK_IN);
    end
    BIT_VALID = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] addr);
    BUS_IDLE = 1'b0;
    m_ovf    = 1'b0;
    send_bits(addr, 8);
  endtask

  task automatic send_byte(input logic [7:0] v);
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else                      m_ovf = 1'b1;
    send_bits(v, 8);
  endtask

  task automatic end_frame(input logic exp_err);
    BUS_IDLE = 1'b1;
    @(negedge CLK_IN);
    check("frame_end_pulse", 32'(FRAME_END), 32'd1);
    check("frame_err_pulse", 32'(FRAME_ERR), 32'(exp_err));
    check("frame_active_off", 32'(FRAME_ACTIVE), 32'd0);
    @(negedge CLK_IN);
    check("frame_end_one_cycle", 32'(FRAME_END), 32'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || BYTE_VALID); i++) @(negedge CLK_IN);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_byte_valid", 32'(BYTE_VALID), 32'd0);
  endtask

  initial begin
    // 1: reset with random strobes
    BUS_IDLE = 1'b0;
    repeat (2) begin
      BIT_VALID = 1'($urandom_range(0, 1));
      BIT_IN    = 1'($urandom_range(0, 1));
      @(negedge CLK_IN);
    end
    check("rst_byte_valid", 32'(BYTE_VALID), 32'd0);
    check("rst_byte_out", 32'(BYTE_OUT), 32'd0);
    check("rst_addr_match", 32'(ADDR_MATCH), 32'd0);
    check("rst_frame_active", 32'(FRAME_ACTIVE), 32'd0);
    check("rst_frame_end", 32'(FRAME_END), 32'd0);
    check("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    BIT_VALID = 1'b0;
    BUS_IDLE  = 1'b1;
    RESET     = 1'b1;
    @(negedge CLK_IN);

    // 2: matched frame, consumer always ready
    BYTE_READY = 1'b1;
    start_frame(8'hA5);
    check("match_addr_match", 32'(ADDR_MATCH), 32'd1);
    check("match_frame_active", 32'(FRAME_ACTIVE), 32'd1);
    send_byte(8'h3C);
    send_byte(8'hC3);
    end_frame(1'b0);
    check("match_addr_match_held", 32'(ADDR_MATCH), 32'd1);
    wait_drain();

    // 3: address miss, data skipped
    start_frame(8'h12);
    check("miss_addr_match", 32'(ADDR_MATCH), 32'd0);
    check("miss_frame_active", 32'(FRAME_ACTIVE), 32'd1);
    send_bits(8'h3C, 8);
    send_bits(8'h99, 8);
    check("miss_no_byte", 32'(BYTE_VALID), 32'd0);
    end_frame(1'b0);

    // 4: broadcast frame overflows the FIFO while the consumer stalls
    BYTE_READY = 1'b0;
    start_frame(8'hFF);
    check("bcast_addr_match", 32'(ADDR_MATCH), 32'd1);
    send_byte(8'h01);
    check("latency_byte_valid", 32'(BYTE_VALID), 32'd1);
    check("latency_byte_out", 32'(BYTE_OUT), 32'h01);
    for (int b = 2; b <= 4; b++) send_byte(8'(b));
    check("full_no_overflow", 32'(OVERFLOW), 32'd0);
    for (int b = 5; b <= 6; b++) send_byte(8'(b));
    check("overflow_set", 32'(OVERFLOW), 32'(m_ovf));
    check("overflow_head", 32'(BYTE_OUT), 32'h01);
    end_frame(1'b0);
    check("overflow_sticky", 32'(OVERFLOW), 32'd1);
    BYTE_READY = 1'b1;
    wait_drain();
    check("overflow_after_drain", 32'(OVERFLOW), 32'd1);

    // 5: partial byte discarded; coincident bit lost
    BUS_IDLE = 1'b0;
    m_ovf    = 1'b0;
    send_bits(8'h01, 1);
    check("start_clears_overflow", 32'(OVERFLOW), 32'(m_ovf));
    check("start_frame_active", 32'(FRAME_ACTIVE), 32'd1);
    send_bits(8'h25, 7);
    send_bits(8'h15, 5);
    BUS_IDLE  = 1'b1;
    BIT_IN    = 1'b1;
    BIT_VALID = 1'b1;
    @(negedge CLK_IN);
    BIT_VALID = 1'b0;
    check("partial_frame_end", 32'(FRAME_END), 32'd1);
    check("partial_frame_err", 32'(FRAME_ERR), 32'd1);
    check("partial_idle", 32'(FRAME_ACTIVE), 32'd0);
    check("partial_no_push", 32'(BYTE_VALID), 32'd0);
    @(negedge CLK_IN);
    check("partial_err_one_cycle", 32'(FRAME_ERR), 32'd0);
    BIT_VALID = 1'b1;
    @(negedge CLK_IN);
    BIT_VALID = 1'b0;
    check("idle_bit_ignored", 32'(FRAME_ACTIVE), 32'd0);

    // 6: reset in the middle of a frame with bytes queued
    BYTE_READY = 1'b0;
    start_frame(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("pre_reset_head", 32'(BYTE_OUT), 32'h11);
    send_bits(8'h05, 3);
    RESET = 1'b0;
    @(negedge CLK_IN);
    exp_q.delete();
    check("midrst_byte_valid", 32'(BYTE_VALID), 32'd0);
    check("midrst_byte_out", 32'(BYTE_OUT), 32'd0);
    check("midrst_frame_active", 32'(FRAME_ACTIVE), 32'd0);
    check("midrst_addr_match", 32'(ADDR_MATCH), 32'd0);
    RESET      = 1'b1;
    BYTE_READY = 1'b1;
    @(negedge CLK_IN);
    start_frame(8'hA5);
    check("post_rst_addr_match", 32'(ADDR_MATCH), 32'd1);
    send_byte(8'h5A);
    end_frame(1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
